uart_rx_ctrl: RTL and testbench

//  Receive-side controller between the APB register file and uart_rx. Shadows

---
 rtl/uart_rx_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_ctrl
// Purpose  : Receive-side controller sitting between the APB register file
//            and uart_rx. Shadows frame configuration and applies it only
//            while the receiver is idle, captures each completed frame into
//            a first-word-fall-through FIFO, drives rts_n flow control with
//            hysteresis from the FIFO fill level, and raises a registered
//            level interrupt.
// Ports    : clk, reset_n (async active-low)
//            cfg_wr, cfg_*            - shadow config load from registers
//            cfg_pending              - shadow written, not yet applied
//            rx_data_bit_num, rx_stop_bit_num, rx_parity_en, rx_parity_type
//                                     - applied config towards uart_rx
//            rx_data, rx_done, rx_parity_error - frame status from uart_rx
//            rts_n                    - flow control, low = send allowed
//            rd_en, rd_data, fifo_empty, fifo_count - FIFO read side
//            ovr_err, ovr_clr         - sticky overrun flag and its clear
//            irq                      - level interrupt
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_ctrl #(
  parameter int FIFO_DEPTH = 16,
  parameter int RTS_THRESH = 12,
  parameter int RTS_RESUME = 8,
  parameter int IRQ_LEVEL  = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          cfg_wr,
  input  logic [1:0]                    cfg_data_bit_num,
  input  logic                          cfg_stop_bit_num,
  input  logic                          cfg_parity_en,
  input  logic                          cfg_parity_type,
  output logic                          cfg_pending,
  output logic [1:0]                    rx_data_bit_num,
  output logic                          rx_stop_bit_num,
  output logic                          rx_parity_en,
  output logic                          rx_parity_type,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_done,
  input  logic                          rx_parity_error,
  output logic                          rts_n,
  input  logic                          rd_en,
  output logic [8:0]                    rd_data,
  output logic                          fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          ovr_err,
  input  logic                          ovr_clr,
  output logic                          irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] THRESH_C = CW'(RTS_THRESH);
  localparam logic [CW-1:0] RESUME_C = CW'(RTS_RESUME);
  localparam logic [CW-1:0] IRQ_C    = CW'(IRQ_LEVEL);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    APPLY = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   apply;

  // Receiver activity edges. rx_done resets high so that a receiver which
  // is idle out of reset never looks like a frame completing.
  logic rx_done_d;
  logic start;
  logic frame_end;

  assign start     = rx_done_d & ~rx_done;
  assign frame_end = ~rx_done_d & rx_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rx_done_d <= 1'b1;
    else          rx_done_d <= rx_done;
  end

  // --------------------------------------------------------------------------
  // Config apply FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    apply     = 1'b0;
    case (state)
      IDLE: begin
        // A starting frame must see a stable config, so start beats apply.
        if (start)            state_nxt = BUSY;
        else if (cfg_pending) state_nxt = APPLY;
      end
      BUSY: begin
        if (frame_end) state_nxt = IDLE;
      end
      APPLY: begin
        apply     = 1'b1;
        state_nxt = start ? BUSY : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  logic [1:0] sh_data_bit_num;
  logic       sh_stop_bit_num;
  logic       sh_parity_en;
  logic       sh_parity_type;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_data_bit_num <= 2'b11;
      sh_stop_bit_num <= 1'b0;
      sh_parity_en    <= 1'b0;
      sh_parity_type  <= 1'b0;
      cfg_pending     <= 1'b0;
      rx_data_bit_num <= 2'b11;
      rx_stop_bit_num <= 1'b0;
      rx_parity_en    <= 1'b0;
      rx_parity_type  <= 1'b0;
    end else begin
      // A write landing in the apply cycle keeps pending set so the newer
      // shadow value gets its own apply pass.
      if (cfg_wr) begin
        sh_data_bit_num <= cfg_data_bit_num;
        sh_stop_bit_num <= cfg_stop_bit_num;
        sh_parity_en    <= cfg_parity_en;
        sh_parity_type  <= cfg_parity_type;
        cfg_pending     <= 1'b1;
      end else if (apply) begin
        cfg_pending     <= 1'b0;
      end
      if (apply) begin
        rx_data_bit_num <= sh_data_bit_num;
        rx_stop_bit_num <= sh_stop_bit_num;
        rx_parity_en    <= sh_parity_en;
        rx_parity_type  <= sh_parity_type;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Receive FIFO
  // --------------------------------------------------------------------------
  logic [7:0]    data_mask;
  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          pop;
  logic          push;
  logic          overrun;

  always_comb begin
    data_mask = 8'hFF;
    case (rx_data_bit_num)
      2'b00:   data_mask = 8'h1F;
      2'b01:   data_mask = 8'h3F;
      2'b10:   data_mask = 8'h7F;
      default: data_mask = 8'hFF;
    endcase
  end

  assign fifo_empty = (fifo_count == '0);
  assign full       = (fifo_count == DEPTH_C);
  assign pop        = rd_en & ~fifo_empty;
  // When full, a simultaneous pop frees the head slot, which is exactly
  // where wr_ptr points, so the push can proceed.
  assign push       = frame_end & (~full | pop);
  assign overrun    = frame_end & full & ~pop;
  assign rd_data    = fifo_empty ? 9'h000 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {rx_parity_error, rx_data & data_mask};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Status: overrun, flow control, interrupt
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovr_err <= 1'b0;
      rts_n   <= 1'b0;
      irq     <= 1'b0;
    end else begin
      if (overrun)      ovr_err <= 1'b1;
      else if (ovr_clr) ovr_err <= 1'b0;

      // Between the two levels rts_n holds its previous value.
      if (fifo_count >= THRESH_C)      rts_n <= 1'b1;
      else if (fifo_count <= RESUME_C) rts_n <= 1'b0;

      irq <= (fifo_count >= IRQ_C) | ovr_err;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_ctrl
// Purpose  : Self-checking bench for uart_rx_ctrl. A vector table covers the
//            config/mask paths; hand-written sequences cover interrupt,
//            pending config, flow-control hysteresis, overrun and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cfg_wr = 1'b0;
  logic [1:0] cfg_data_bit_num = 2'b11;
  logic       cfg_stop_bit_num = 1'b0;
  logic       cfg_parity_en = 1'b0;
  logic       cfg_parity_type = 1'b0;
  logic       cfg_pending;
  logic [1:0] rx_data_bit_num;
  logic       rx_stop_bit_num;
  logic       rx_parity_en;
  logic       rx_parity_type;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b1;
  logic       rx_parity_error = 1'b0;
  logic       rts_n;
  logic       rd_en = 1'b0;
  logic [8:0] rd_data;
  logic       fifo_empty;
  logic [4:0] fifo_count;
  logic       ovr_err;
  logic       ovr_clr = 1'b0;
  logic       irq;

  uart_rx_ctrl #(
    .FIFO_DEPTH(16), .RTS_THRESH(12), .RTS_RESUME(8), .IRQ_LEVEL(1)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_wr(cfg_wr), .cfg_data_bit_num(cfg_data_bit_num),
    .cfg_stop_bit_num(cfg_stop_bit_num), .cfg_parity_en(cfg_parity_en),
    .cfg_parity_type(cfg_parity_type), .cfg_pending(cfg_pending),
    .rx_data_bit_num(rx_data_bit_num), .rx_stop_bit_num(rx_stop_bit_num),
    .rx_parity_en(rx_parity_en), .rx_parity_type(rx_parity_type),
    .rx_data(rx_data), .rx_done(rx_done), .rx_parity_error(rx_parity_error),
    .rts_n(rts_n), .rd_en(rd_en), .rd_data(rd_data), .fifo_empty(fifo_empty),
    .fifo_count(fifo_count), .ovr_err(ovr_err), .ovr_clr(ovr_clr), .irq(irq)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [8:0] q[$];

  typedef struct {
    logic [1:0] bits;
    logic       stop;
    logic       pe;
    logic       pt;
    logic [7:0] data;
    logic       perr;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_start();
    rx_done = 1'b0;
    tick();
  endtask

  task automatic frame_finish(input logic [7:0] d, input logic p);
    rx_data         = d;
    rx_parity_error = p;
    rx_done         = 1'b1;
    tick();
  endtask

  // Full frame in 8-bit mode; model keeps only what fits.
  task automatic send8(input logic [7:0] d);
    frame_start();
    tick();
    frame_finish(d, 1'b0);
    if (q.size() < 16) q.push_back({1'b0, d});
  endtask

  task automatic apply_cfg(input logic [1:0] b, input logic s, input logic pe, input logic pt);
    cfg_data_bit_num = b;
    cfg_stop_bit_num = s;
    cfg_parity_en    = pe;
    cfg_parity_type  = pt;
    cfg_wr = 1'b1;
    tick();
    cfg_wr = 1'b0;
    tick();
    tick();
  endtask

  task automatic pop_check(input string name);
    logic [8:0] e;
    e = (q.size() > 0) ? q[0] : 9'h000;
    check(name, 32'(rd_data), 32'(e));
    if (q.size() > 0) void'(q.pop_front());
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_count"},   32'(fifo_count), 32'd0);
    check({tag, "_empty"},   32'(fifo_empty), 32'd1);
    check({tag, "_rd_data"}, 32'(rd_data), 32'd0);
    check({tag, "_rts_n"},   32'(rts_n), 32'd0);
    check({tag, "_ovr"},     32'(ovr_err), 32'd0);
    check({tag, "_irq"},     32'(irq), 32'd0);
    check({tag, "_pending"}, 32'(cfg_pending), 32'd0);
    check({tag, "_bits"},    32'(rx_data_bit_num), 32'd3);
    check({tag, "_stop"},    32'(rx_stop_bit_num), 32'd0);
    check({tag, "_pe"},      32'(rx_parity_en), 32'd0);
    check({tag, "_pt"},      32'(rx_parity_type), 32'd0);
  endtask

  initial begin
    vecs[0] = '{2'd3, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 9'h0A5};
    vecs[1] = '{2'd3, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b1, 9'h15A};
    vecs[2] = '{2'd0, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 9'h01F};
    vecs[3] = '{2'd0, 1'b1, 1'b1, 1'b0, 8'hE3, 1'b1, 9'h103};
    vecs[4] = '{2'd1, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 9'h03F};
    vecs[5] = '{2'd1, 1'b0, 1'b1, 1'b1, 8'hC1, 1'b0, 9'h001};
    vecs[6] = '{2'd2, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b1, 9'h17F};
    vecs[7] = '{2'd2, 1'b0, 1'b1, 1'b0, 8'h80, 1'b0, 9'h000};
    vecs[8] = '{2'd3, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b1, 9'h13C};

    // Reset state
    tick();
    tick();
    check_reset_outputs("reset");
    #3 reset_n = 1'b1;
    tick();
    tick();
    check("idle_count", 32'(fifo_count), 32'd0);

    // Single frame, interrupt raise and clear
    send8(8'hA5);
    check("a5_count", 32'(fifo_count), 32'd1);
    check("a5_rd_data", 32'(rd_data), 32'h0A5);
    tick();
    check("a5_irq", 32'(irq), 32'd1);
    pop_check("a5_pop");
    check("a5_empty", 32'(fifo_empty), 32'd1);
    tick();
    check("a5_irq_clr", 32'(irq), 32'd0);

    // Config/mask table
    for (int i = 0; i < 9; i++) begin
      apply_cfg(vecs[i].bits, vecs[i].stop, vecs[i].pe, vecs[i].pt);
      check($sformatf("v%0d_bits", i), 32'(rx_data_bit_num), 32'(vecs[i].bits));
      check($sformatf("v%0d_stop", i), 32'(rx_stop_bit_num), 32'(vecs[i].stop));
      check($sformatf("v%0d_pe", i),   32'(rx_parity_en), 32'(vecs[i].pe));
      check($sformatf("v%0d_pt", i),   32'(rx_parity_type), 32'(vecs[i].pt));
      check($sformatf("v%0d_pending", i), 32'(cfg_pending), 32'd0);
      frame_start();
      tick();
      frame_finish(vecs[i].data, vecs[i].perr);
      check($sformatf("v%0d_count", i), 32'(fifo_count), 32'd1);
      check($sformatf("v%0d_rd_data", i), 32'(rd_data), 32'(vecs[i].exp));
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check($sformatf("v%0d_empty", i), 32'(fifo_empty), 32'd1);
    end

    // Config write while busy is held off until the frame completes
    frame_start();
    cfg_data_bit_num = 2'b00;
    cfg_stop_bit_num = 1'b0;
    cfg_parity_en    = 1'b0;
    cfg_parity_type  = 1'b0;
    cfg_wr = 1'b1;
    tick();
    cfg_wr = 1'b0;
    check("busy_pending", 32'(cfg_pending), 32'd1);
    check("busy_bits_held", 32'(rx_data_bit_num), 32'd3);
    frame_finish(8'hC3, 1'b0);
    check("end_bits_held", 32'(rx_data_bit_num), 32'd3);
    check("end_rd_data_8bit", 32'(rd_data), 32'h0C3);
    tick();
    tick();
    check("applied_bits", 32'(rx_data_bit_num), 32'd0);
    check("applied_pending", 32'(cfg_pending), 32'd0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    frame_start();
    tick();
    frame_finish(8'hFF, 1'b0);
    check("5bit_rd_data", 32'(rd_data), 32'h01F);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    apply_cfg(2'b11, 1'b0, 1'b0, 1'b0);
    check("restore_bits", 32'(rx_data_bit_num), 32'd3);

    // rts_n hysteresis
    for (int i = 0; i < 11; i++) send8(8'(8'h20 + i));
    tick();
    check("rts_11", 32'(rts_n), 32'd0);
    send8(8'h2B);
    tick();
    check("rts_12", 32'(rts_n), 32'd1);
    for (int i = 0; i < 3; i++) pop_check("rts_pop");
    tick();
    check("rts_9_count", 32'(fifo_count), 32'd9);
    check("rts_9", 32'(rts_n), 32'd1);
    pop_check("rts_pop");
    tick();
    check("rts_8", 32'(rts_n), 32'd0);
    while (q.size() > 0) pop_check("rts_drain");
    check("rts_drained", 32'(fifo_empty), 32'd1);

    // Overrun
    for (int i = 0; i < 17; i++) send8(8'(8'h40 + i));
    check("ovr_count", 32'(fifo_count), 32'd16);
    check("ovr_set", 32'(ovr_err), 32'd1);
    tick();
    check("ovr_irq", 32'(irq), 32'd1);
    check("ovr_rts", 32'(rts_n), 32'd1);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check("ovr_cleared", 32'(ovr_err), 32'd0);

    // Full FIFO with push and pop on the same clock
    frame_start();
    check("full_head", 32'(rd_data), 32'(q[0]));
    rd_en = 1'b1;
    frame_finish(8'hEE, 1'b0);
    rd_en = 1'b0;
    void'(q.pop_front());
    q.push_back(9'h0EE);
    check("pushpop_count", 32'(fifo_count), 32'd16);
    check("pushpop_ovr", 32'(ovr_err), 32'd0);

    // Overrun and clear on the same clock: set wins
    frame_start();
    ovr_clr = 1'b1;
    frame_finish(8'h77, 1'b0);
    ovr_clr = 1'b0;
    check("setwins_ovr", 32'(ovr_err), 32'd1);
    check("setwins_count", 32'(fifo_count), 32'd16);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check("setwins_clr", 32'(ovr_err), 32'd0);
    while (q.size() > 0) pop_check("full_drain");

    // Pop on empty is ignored
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("empty_pop_count", 32'(fifo_count), 32'd0);
    check("empty_pop_empty", 32'(fifo_empty), 32'd1);
    check("empty_pop_rd_data", 32'(rd_data), 32'd0);

    // Reset mid-frame with entries and pending config
    apply_cfg(2'b10, 1'b1, 1'b1, 1'b0);
    check("pre_rst_bits", 32'(rx_data_bit_num), 32'd2);
    for (int i = 0; i < 5; i++) send8(8'(8'h10 + i));
    check("pre_rst_count", 32'(fifo_count), 32'd5);
    frame_start();
    cfg_data_bit_num = 2'b00;
    cfg_wr = 1'b1;
    tick();
    cfg_wr = 1'b0;
    check("pre_rst_pending", 32'(cfg_pending), 32'd1);
    #3 reset_n = 1'b0;
    #2;
    q.delete();
    check_reset_outputs("async_rst");
    rx_done = 1'b1;
    tick();
    tick();
    #3 reset_n = 1'b1;
    tick();
    tick();
    tick();
    check_reset_outputs("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
